register_file: RTL and testbench

- Dual-read, single-write register file that feeds the unsigned ALU.
- Read ports A and B drive the ALU operand inputs rf_A and rf_B.
- The write port accepts results returning from the shifter stage, closing the datapath loop.
- A bulk-load sequencer fills every register from an external source before a run starts.

---
 rtl/register_file.sv | 132 +++++++++++++
 tb/tb_register_file.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: dual-read, single-write register file feeding the ALU.
//
// Read ports A/B are registered (1-cycle latency) and are active in every
// state. The write port takes shifter results while in RUN. A bulk-load
// sequencer (LOAD state) fills registers 0..DEPTH-1 in order from ld_data
// and then returns to RUN with a one-cycle ld_done pulse.
//
// Optional build macro: RF_WRITE_BYPASS_EN
//   defined   - a write on the same edge as a read of the same address
//               forwards the written data to rf_A / rf_B.
//   undefined - same-edge reads return the old register contents.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   wr_en/wr_addr/wr_data   shifter-side write port (honoured in RUN only)
//   rd_addr_A/rd_addr_B     read addresses
//   rf_A/rf_B               registered read data to the ALU
//   ld_start                pulse requesting a bulk load (RUN only)
//   ld_valid/ld_data        load word handshake
//   ld_ready                high while accepting load words
//   ld_done                 one-cycle pulse after the last load word
//   busy                    high while in LOAD
//
// state | meaning
// RUN   | normal operation, shifter writes honoured
// LOAD  | bulk load in progress, shifter writes ignored

module register_file #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_A,
    input  logic [ADDR_W-1:0] rd_addr_B,
    output logic [WIDTH-1:0]  rf_A,
    output logic [WIDTH-1:0]  rf_B,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [WIDTH-1:0]  ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy
);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               ld_done_q, ld_done_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   rf_a_q, rf_a_d;
    logic [WIDTH-1:0]   rf_b_q, rf_b_d;

    // Unified write port: shifter writes in RUN, load words in LOAD.
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [WIDTH-1:0]   wdata;

    always_comb begin
        we        = 1'b0;
        waddr     = wr_addr;
        wdata     = wr_data;
        state_d   = state_q;
        ptr_d     = ptr_q;
        ld_done_d = 1'b0;
        unique case (state_q)
            RUN: begin
                we = wr_en;
                if (ld_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    we    = 1'b1;
                    waddr = ptr_q;
                    wdata = ld_data;
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d   = RUN;
                        ptr_d     = '0;
                        ld_done_d = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        rf_a_d = mem_q[rd_addr_A];
        rf_b_d = mem_q[rd_addr_B];
`ifdef RF_WRITE_BYPASS_EN
        if (we && (waddr == rd_addr_A)) rf_a_d = wdata;
        if (we && (waddr == rd_addr_B)) rf_b_d = wdata;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            ptr_q     <= '0;
            ld_done_q <= 1'b0;
            rf_a_q    <= '0;
            rf_b_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ld_done_q <= ld_done_d;
            rf_a_q    <= rf_a_d;
            rf_b_q    <= rf_b_d;
            if (we) mem_q[waddr] <= wdata;
        end
    end

    assign rf_A     = rf_a_q;
    assign rf_B     = rf_b_q;
    assign ld_done  = ld_done_q;
    assign ld_ready = (state_q == LOAD);
    assign busy     = (state_q == LOAD);

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr_A, rd_addr_B;
    logic [7:0] rf_A, rf_B;
    logic       ld_start, ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready, ld_done, busy;

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;

    // Reference model: memory array, load flag, next load slot.
    logic [7:0] m_mem [8];
    bit         m_load;
    logic [2:0] m_ptr;

    register_file #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B),
        .rf_A(rf_A), .rf_B(rf_B),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        ld_start = 0; ld_valid = 0; ld_data = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        m_load = 0;
        m_ptr  = 0;
    endtask

    // One clock: predict from current inputs, clock, then compare.
    task automatic tick();
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd, ea, eb;
        logic       edone;
        we = 0; wa = wr_addr; wd = wr_data; edone = 0;
        if (!m_load) we = wr_en;
        else if (ld_valid) begin we = 1; wa = m_ptr; wd = ld_data; end
        ea = m_mem[rd_addr_A];
        eb = m_mem[rd_addr_B];
`ifdef RF_WRITE_BYPASS_EN
        if (we && wa == rd_addr_A) ea = wd;
        if (we && wa == rd_addr_B) eb = wd;
`endif
        if (we) m_mem[wa] = wd;
        if (!m_load) begin
            if (ld_start) begin m_load = 1; m_ptr = 0; end
        end else if (ld_valid) begin
            if (m_ptr == 3'd7) begin m_load = 0; m_ptr = 0; edone = 1; end
            else m_ptr = m_ptr + 3'd1;
        end
        @(posedge clk);
        #1;
        check("rf_A", rf_A, ea);
        check("rf_B", rf_B, eb);
        check("ld_done", ld_done, edone);
        check("ld_ready", ld_ready, m_load);
        check("busy", busy, m_load);
        if (ld_done) done_cnt++;
    endtask

    // Assert reset mid-cycle and verify outputs clear without a clock edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1;
        #1;
        check({tag, "_rfA"}, rf_A, 0);
        check({tag, "_rfB"}, rf_B, 0);
        check({tag, "_ready"}, ld_ready, 0);
        check({tag, "_done"}, ld_done, 0);
        check({tag, "_busy"}, busy, 0);
        model_clear();
        #3;
        reset = 0;
        idle_inputs();
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic load_word(input logic [7:0] d);
        ld_valid = 1; ld_data = d;
        tick();
        ld_valid = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        rd_addr_A = 0; rd_addr_B = 0;
        model_clear();
        @(posedge clk); #1;
        do_reset("rst0");

        // All addresses read zero after reset.
        for (int k = 0; k < 8; k++) begin
            rd_addr_A = 3'(k); rd_addr_B = 3'(7 - k);
            tick();
            check("rst_read_A", rf_A, 8'h00);
        end

        // Directed write/read.
        write(3'd3, 8'hA5);
        write(3'd6, 8'h3C);
        rd_addr_A = 3; rd_addr_B = 6;
        tick();
        check("wr_rd_A", rf_A, 8'hA5);
        check("wr_rd_B", rf_B, 8'h3C);
        rd_addr_B = 3;
        tick();
        check("same_addr_A", rf_A, 8'hA5);
        check("same_addr_B", rf_B, 8'hA5);

        // Bulk load with a 2-cycle stall after word 3, wr_en forced during load.
        done_cnt = 0;
        ld_start = 1; tick(); ld_start = 0;
        check("load_busy", busy, 1);
        wr_en = 1; wr_addr = 0; wr_data = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            load_word(8'h10 + 8'(k));
            if (k == 2) begin tick(); tick(); end
        end
        wr_en = 0;
        check("load_done_pulses", done_cnt, 1);
        tick();
        check("post_load_busy", busy, 0);
        check("post_load_ready", ld_ready, 0);
        check("post_load_done", ld_done, 0);
        for (int k = 0; k < 8; k++) begin
            rd_addr_A = 3'(k);
            tick();
            check("load_val", rf_A, 8'h10 + 8'(k));
        end

        // Reset mid-load after 4 words.
        done_cnt = 0;
        ld_start = 1; tick(); ld_start = 0;
        for (int k = 0; k < 4; k++) load_word(8'h80 + 8'(k));
        do_reset("rst_load");
        for (int k = 0; k < 8; k++) begin
            rd_addr_A = 3'(k);
            tick();
            check("rst_load_clear", rf_A, 8'h00);
        end
        check("rst_load_no_done", done_cnt, 0);
        ld_start = 1; tick(); ld_start = 0;
        load_word(8'hC7);
        rd_addr_A = 0;
        tick();
        check("reload_addr0", rf_A, 8'hC7);
        for (int k = 1; k < 8; k++) load_word(8'hC7 + 8'(k));
        tick();

        // Read during write on the same edge.
        write(3'd2, 8'h11);
        rd_addr_A = 2;
        write(3'd2, 8'h55);
`ifdef RF_WRITE_BYPASS_EN
        check("rdw_first", rf_A, 8'h55);
`else
        check("rdw_first", rf_A, 8'h11);
`endif
        tick();
        check("rdw_second", rf_A, 8'h55);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = 3'($urandom);
            wr_data   = 8'($urandom);
            rd_addr_A = 3'($urandom);
            rd_addr_B = 3'($urandom);
            ld_start  = ($urandom_range(0, 19) == 0);
            ld_valid  = 1'($urandom_range(0, 1));
            ld_data   = 8'($urandom);
            tick();
            if (n == 300) do_reset("rst_rand");
        end
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
